// File: rtl/vend_pkg.sv
// Shared types and default constants for the vending output sequencer.
package vend_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MOTOR,
    ST_EJECT_ON,
    ST_EJECT_GAP,
    ST_FAULT
  } vend_state_e;

  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_SODA,
    SEL_DIET
  } prod_sel_e;

  localparam int DEF_STOCK_W       = 6;
  localparam int DEF_STOCK_MAX     = 20;
  localparam int DEF_PULSE_CYCLES  = 4;
  localparam int DEF_GAP_CYCLES    = 2;
  localparam int DEF_MOTOR_TIMEOUT = 64;
  localparam int CHANGE_W          = 3;

endpackage

// File: rtl/nickel_ejector.sv
// Emits `count` solenoid pulses, each PULSE_CYCLES high then GAP_CYCLES low.
// Phase-end strobes let the parent FSM track ON/GAP in lockstep.
module nickel_ejector
  import vend_pkg::*;
#(
  parameter int PULSE_CYCLES = DEF_PULSE_CYCLES,
  parameter int GAP_CYCLES   = DEF_GAP_CYCLES
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [CHANGE_W-1:0] count,
  output logic                nickel_eject,
  output logic                pulse_end,
  output logic                gap_end,
  output logic                done
);

  localparam int LONGEST = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int TW      = $clog2(LONGEST) + 1;
  localparam logic [TW-1:0] PULSE_LAST = TW'(PULSE_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LAST   = TW'(GAP_CYCLES - 1);

  logic                active_q, active_d;
  logic                eject_q, eject_d;
  logic [TW-1:0]       timer_q, timer_d;
  logic [CHANGE_W-1:0] count_q, count_d;

  assign pulse_end    = active_q &  eject_q & (timer_q == PULSE_LAST);
  assign gap_end      = active_q & ~eject_q & (timer_q == GAP_LAST);
  assign done         = gap_end & (count_q == CHANGE_W'(1));
  assign nickel_eject = eject_q;

  // NOTE: every signal gets a default before the decision tree, so no path can infer a latch.
  always_comb begin
    active_d = active_q;
    eject_d  = eject_q;
    timer_d  = timer_q;
    count_d  = count_q;
    if (start && !active_q && (count != '0)) begin
      active_d = 1'b1;
      eject_d  = 1'b1;
      timer_d  = '0;
      count_d  = count;
    end else if (pulse_end) begin
      eject_d = 1'b0;
      timer_d = '0;
    end else if (gap_end) begin
      count_d = count_q - 1'b1;
      timer_d = '0;
      if (count_q == CHANGE_W'(1)) active_d = 1'b0;
      else                         eject_d  = 1'b1;
    end else if (active_q) begin
      timer_d = timer_q + 1'b1;
    end
  end

  // NOTE: non-blocking assignments so every register updates from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      active_q <= 1'b0;
      eject_q  <= 1'b0;
      timer_q  <= '0;
      count_q  <= '0;
    end else begin
      active_q <= active_d;
      eject_q  <= eject_d;
      timer_q  <= timer_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/vend_dispenser.sv
// Output-side vending sequencer: product motors, change ejection, stock and
// fault tracking. All status outputs are registered.
module vend_dispenser
  import vend_pkg::*;
#(
  parameter int STOCK_W       = DEF_STOCK_W,
  parameter int STOCK_MAX     = DEF_STOCK_MAX,
  parameter int PULSE_CYCLES  = DEF_PULSE_CYCLES,
  parameter int GAP_CYCLES    = DEF_GAP_CYCLES,
  parameter int MOTOR_TIMEOUT = DEF_MOTOR_TIMEOUT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                give_soda,
  input  logic                give_diet,
  input  logic [CHANGE_W-1:0] change_count,
  input  logic                motor_done,
  input  logic                refill,
  input  logic                fault_clear,
  output logic                soda_motor,
  output logic                diet_motor,
  output logic                nickel_eject,
  output logic                busy,
  output logic                vend_done,
  output logic                sold_out_hit,
  output logic                soda_empty,
  output logic                diet_empty,
  output logic                fault
);

  localparam int MTW = $clog2(MOTOR_TIMEOUT + 1);
  localparam logic [MTW-1:0]     MOTOR_LAST = MTW'(MOTOR_TIMEOUT - 1);
  localparam logic [STOCK_W-1:0] STOCK_FULL = STOCK_W'(STOCK_MAX);

  vend_state_e         state_q, state_d;
  prod_sel_e           sel_q, sel_d, req_sel;
  logic [CHANGE_W-1:0] change_q, change_d, ej_count;
  logic [STOCK_W-1:0]  soda_stock_q, soda_stock_d, diet_stock_q, diet_stock_d;
  logic [MTW-1:0]      mtimer_q, mtimer_d;
  logic soda_motor_q, soda_motor_d, diet_motor_q, diet_motor_d;
  logic vend_done_q, vend_done_d, sold_out_q, sold_out_d;
  logic busy_q, fault_q, soda_empty_q, diet_empty_q;
  logic request, req_avail, ej_start, ej_pulse_end, ej_gap_end, ej_done;

  // Soda wins when both give lines are high.
  assign request   = give_soda | give_diet | (change_count != '0);
  assign req_sel   = give_soda ? SEL_SODA : (give_diet ? SEL_DIET : SEL_NONE);
  assign req_avail = ((req_sel == SEL_SODA) && (soda_stock_q != '0)) ||
                     ((req_sel == SEL_DIET) && (diet_stock_q != '0));

  nickel_ejector #(
    .PULSE_CYCLES (PULSE_CYCLES),
    .GAP_CYCLES   (GAP_CYCLES)
  ) u_ejector (
    .clk          (clk),
    .reset        (reset),
    .start        (ej_start),
    .count        (ej_count),
    .nickel_eject (nickel_eject),
    .pulse_end    (ej_pulse_end),
    .gap_end      (ej_gap_end),
    .done         (ej_done)
  );

  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    change_d     = change_q;
    soda_stock_d = soda_stock_q;
    diet_stock_d = diet_stock_q;
    mtimer_d     = mtimer_q;
    soda_motor_d = 1'b0;
    diet_motor_d = 1'b0;
    vend_done_d  = 1'b0;
    sold_out_d   = 1'b0;
    ej_start     = 1'b0;
    ej_count     = change_q;
    unique case (state_q)
      ST_IDLE: begin
        if (request) begin
          sel_d    = req_sel;
          change_d = change_count;
          ej_count = change_count;
          mtimer_d = '0;
          if (req_avail) begin
            state_d      = ST_MOTOR;
            soda_motor_d = (req_sel == SEL_SODA);
            diet_motor_d = (req_sel == SEL_DIET);
          end else begin
            sold_out_d = (req_sel != SEL_NONE);
            if (change_count != '0) begin
              ej_start = 1'b1;
              state_d  = ST_EJECT_ON;
            end else begin
              vend_done_d = 1'b1;
            end
          end
        end else if (refill) begin
          soda_stock_d = STOCK_FULL;
          diet_stock_d = STOCK_FULL;
        end
      end
      ST_MOTOR: begin
        if (motor_done) begin
          if ((sel_q == SEL_SODA) && (soda_stock_q != '0)) soda_stock_d = soda_stock_q - 1'b1;
          if ((sel_q == SEL_DIET) && (diet_stock_q != '0)) diet_stock_d = diet_stock_q - 1'b1;
          if (change_q != '0) begin
            ej_start = 1'b1;
            state_d  = ST_EJECT_ON;
          end else begin
            state_d     = ST_IDLE;
            vend_done_d = 1'b1;
          end
        end else if (mtimer_q == MOTOR_LAST) begin
          state_d = ST_FAULT;  // pending change is dropped with the jammed product
        end else begin
          mtimer_d     = mtimer_q + 1'b1;
          soda_motor_d = (sel_q == SEL_SODA);
          diet_motor_d = (sel_q == SEL_DIET);
        end
      end
      ST_EJECT_ON: begin
        if (ej_pulse_end) state_d = ST_EJECT_GAP;
      end
      ST_EJECT_GAP: begin
        if (ej_done) begin
          state_d     = ST_IDLE;
          vend_done_d = 1'b1;
        end else if (ej_gap_end) begin
          state_d = ST_EJECT_ON;
        end
      end
      ST_FAULT: begin
        if (fault_clear) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      sel_q        <= SEL_NONE;
      change_q     <= '0;
      soda_stock_q <= STOCK_FULL;
      diet_stock_q <= STOCK_FULL;
      mtimer_q     <= '0;
      soda_motor_q <= 1'b0;
      diet_motor_q <= 1'b0;
      vend_done_q  <= 1'b0;
      sold_out_q   <= 1'b0;
      busy_q       <= 1'b0;
      fault_q      <= 1'b0;
      soda_empty_q <= 1'b0;
      diet_empty_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      change_q     <= change_d;
      soda_stock_q <= soda_stock_d;
      diet_stock_q <= diet_stock_d;
      mtimer_q     <= mtimer_d;
      soda_motor_q <= soda_motor_d;
      diet_motor_q <= diet_motor_d;
      vend_done_q  <= vend_done_d;
      sold_out_q   <= sold_out_d;
      busy_q       <= (state_d != ST_IDLE);
      fault_q      <= (state_d == ST_FAULT);
      soda_empty_q <= (soda_stock_d == '0);
      diet_empty_q <= (diet_stock_d == '0);
    end
  end

  assign soda_motor   = soda_motor_q;
  assign diet_motor   = diet_motor_q;
  assign vend_done    = vend_done_q;
  assign sold_out_hit = sold_out_q;
  assign busy         = busy_q;
  assign fault        = fault_q;
  assign soda_empty   = soda_empty_q;
  assign diet_empty   = diet_empty_q;

endmodule

// File: tb/tb_vend_dispenser.sv
// Directed bench for vend_dispenser: expected per-cycle output vectors are
// queued with each stimulus and popped one per clock after the edge.
module tb_vend_dispenser;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       give_soda = 1'b0, give_diet = 1'b0;
  logic [2:0] change_count = '0;
  logic       motor_done = 1'b0, refill = 1'b0, fault_clear = 1'b0;
  logic       soda_motor, diet_motor, nickel_eject, busy, vend_done, sold_out_hit;
  logic       soda_empty, diet_empty, fault;

  vend_dispenser dut (
    .clk          (clk),
    .reset        (reset),
    .give_soda    (give_soda),
    .give_diet    (give_diet),
    .change_count (change_count),
    .motor_done   (motor_done),
    .refill       (refill),
    .fault_clear  (fault_clear),
    .soda_motor   (soda_motor),
    .diet_motor   (diet_motor),
    .nickel_eject (nickel_eject),
    .busy         (busy),
    .vend_done    (vend_done),
    .sold_out_hit (sold_out_hit),
    .soda_empty   (soda_empty),
    .diet_empty   (diet_empty),
    .fault        (fault)
  );

  always #5 clk = ~clk;

  // {soda_motor, diet_motor, nickel_eject, busy, vend_done, sold_out_hit, fault}
  wire [6:0] outs = {soda_motor, diet_motor, nickel_eject, busy, vend_done, sold_out_hit, fault};
  localparam logic [6:0] V_IDLE    = 7'b0000000;
  localparam logic [6:0] V_SODA    = 7'b1001000;
  localparam logic [6:0] V_DIET    = 7'b0101000;
  localparam logic [6:0] V_EJ      = 7'b0011000;
  localparam logic [6:0] V_GAP     = 7'b0001000;
  localparam logic [6:0] V_DONE    = 7'b0000100;
  localparam logic [6:0] V_SOLD_EJ = 7'b0011010;
  localparam logic [6:0] V_FAULT   = 7'b0001001;

  typedef struct {
    string      tag;
    logic [6:0] vec;
  } exp_t;
  exp_t sb[$];

  int n_checks = 0, n_pass = 0, n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input logic [6:0] vec, input int k);
    for (int i = 0; i < k; i++) sb.push_back('{tag, vec});
  endtask

  task automatic push_eject(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      push({tag, "_on"}, V_EJ, 4);
      push({tag, "_gap"}, V_GAP, 2);
    end
  endtask

  // Advance k clocks, comparing outputs 1 time unit after each rising edge.
  task automatic run(input int k);
    exp_t e;
    for (int i = 0; i < k; i++) begin
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $error("FAIL sb_underflow: observed outputs %0h with no expected entry", outs);
      end else begin
        e = sb.pop_front();
        check(e.tag, outs, e.vec);
      end
    end
  endtask

  task automatic drain_soda(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      push({tag, "_motor"}, V_SODA, 1);
      push({tag, "_done"}, V_DONE, 1);
      give_soda = 1'b1;
      run(1);
      give_soda  = 1'b0;
      motor_done = 1'b1;
      run(1);
      motor_done = 1'b0;
      check({tag, "_soda_empty"}, soda_empty, (i == n - 1));
    end
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_outs", outs, V_IDLE);
    check("rst_soda_empty", soda_empty, 1'b0);
    check("rst_diet_empty", diet_empty, 1'b0);
    reset = 1'b0;
    push("post_rst", V_IDLE, 1);
    run(1);

    // Soda + 1 nickel, motor_done sampled on the 6th motor cycle
    push("soda1_motor", V_SODA, 6);
    push_eject("soda1_ej", 1);
    push("soda1_done", V_DONE, 1);
    push("soda1_idle", V_IDLE, 1);
    give_soda = 1'b1; change_count = 3'd1;
    run(1);
    give_soda = 1'b0; change_count = 3'd0;
    run(5);
    motor_done = 1'b1;
    run(1);
    motor_done = 1'b0;
    run(7);

    // Change only: four pulses, busy for 24 cycles
    push_eject("chg4", 4);
    push("chg4_done", V_DONE, 1);
    change_count = 3'd4;
    run(1);
    change_count = 3'd0;
    run(24);

    // Diet jam: 64 motor cycles, fault, change discarded
    push("jam_motor", V_DIET, 64);
    push("jam_fault", V_FAULT, 3);
    push("jam_clear", V_IDLE, 1);
    give_diet = 1'b1; change_count = 3'd3;
    run(1);
    give_diet = 1'b0; change_count = 3'd0;
    run(66);
    fault_clear = 1'b1;
    run(1);
    fault_clear = 1'b0;
    check("jam_diet_empty", diet_empty, 1'b0);

    // Both give lines: soda wins; request during busy is ignored
    push("both_motor", V_SODA, 3);
    push("both_done", V_DONE, 1);
    push("both_idle", V_IDLE, 2);
    give_soda = 1'b1; give_diet = 1'b1;
    run(1);
    give_soda = 1'b0;
    run(2);
    give_diet  = 1'b0;
    motor_done = 1'b1;
    run(1);
    motor_done = 1'b0;
    run(2);

    // Drain the remaining 18 sodas (20 - 2 already vended)
    drain_soda("drain1", 18);
    check("drain1_diet_empty", diet_empty, 1'b0);

    // Empty soda with 2 nickels: sold-out pulse, no motor, change returned
    push("sold_ej", V_SOLD_EJ, 1);
    push("sold_on", V_EJ, 3);
    push("sold_gap", V_GAP, 2);
    push_eject("sold_ej2", 1);
    push("sold_done", V_DONE, 1);
    push("sold_idle", V_IDLE, 1);
    give_soda = 1'b1; change_count = 3'd2;
    run(1);
    give_soda = 1'b0; change_count = 3'd0;
    run(13);
    check("sold_soda_empty", soda_empty, 1'b1);

    // Refill coinciding with a request is dropped
    push("rfq_motor", V_DIET, 1);
    push("rfq_done", V_DONE, 1);
    give_diet = 1'b1; refill = 1'b1;
    run(1);
    give_diet = 1'b0; refill = 1'b0;
    motor_done = 1'b1;
    run(1);
    motor_done = 1'b0;
    check("rfq_soda_empty", soda_empty, 1'b1);

    // Async reset during the second eject pulse
    push_eject("rst_ej", 1);
    push("rst_ej2_on", V_EJ, 2);
    change_count = 3'd3;
    run(1);
    change_count = 3'd0;
    run(7);
    #2 reset = 1'b1;
    #1;
    check("arst_outs", outs, V_IDLE);
    check("arst_soda_empty", soda_empty, 1'b0);
    check("arst_sb_left", sb.size(), 0);
    @(negedge clk);
    reset = 1'b0;
    push("arst_idle", V_IDLE, 2);
    run(2);

    // Stock reloaded to 20 by reset; then plain refill restores it
    drain_soda("drain2", 20);
    push("refill", V_IDLE, 1);
    refill = 1'b1;
    run(1);
    refill = 1'b0;
    check("refill_soda_empty", soda_empty, 1'b0);
    check("refill_diet_empty", diet_empty, 1'b0);
    check("sb_leftover", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
